// File: rtl/store_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : store_monitor
// | Purpose  : Watches the data-memory write port and logs stores in a FIFO.
// |            Flags PASS, FAIL or TIMEOUT, which stay set until reset.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
module store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'h00008054,
  parameter logic [31:0] PASS_DATA      = 32'h00000001,
  parameter logic [31:0] ALLOW_LO       = 32'h00008000,
  parameter logic [31:0] ALLOW_HI       = 32'h00008050,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        log_rd,
  output logic        log_valid,
  output logic [31:0] log_adr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic [15:0] store_count,
  output logic [31:0] cycle_count,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout
);

  localparam int unsigned IDX_W        = $clog2(LOG_DEPTH);
  localparam int unsigned PTR_W        = IDX_W + 1;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_PASS    = 2'd1,
    S_FAIL    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      mem_adr  [LOG_DEPTH];
  logic [31:0]      mem_data [LOG_DEPTH];

  logic in_run;
  logic push_req;
  logic push;
  logic pop;
  logic empty;
  logic full;
  logic is_pass_store;
  logic in_window;

  assign in_run        = (state == S_RUN);
  assign push_req      = in_run && memwrite;
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                         (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign pop           = log_rd && !empty;
  // A simultaneous pop frees the slot the push is about to take.
  assign push          = push_req && (!full || pop);
  assign is_pass_store = (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
  assign in_window     = (dataadr >= ALLOW_LO) && (dataadr <= ALLOW_HI) &&
                         (dataadr != PASS_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pass       = 1'b0;
    fail       = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_RUN: begin
        if (memwrite) begin
          if (is_pass_store) begin
            state_next = S_PASS;
          end else if (!in_window) begin
            state_next = S_FAIL;
          end
        end else if (cycle_count == TIMEOUT_LAST) begin
          state_next = S_TIMEOUT;
        end
      end
      S_PASS:    pass = 1'b1;
      S_FAIL:    fail = 1'b1;
      S_TIMEOUT: begin
        fail    = 1'b1;
        timeout = 1'b1;
      end
      default: state_next = S_RUN;
    endcase
    done = pass | fail;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_count <= 16'h0000;
      cycle_count <= 32'h0000_0000;
    end else begin
      if (push_req && (store_count != 16'hFFFF)) begin
        store_count <= store_count + 16'h0001;
      end
      // The timeout edge itself does not advance the count.
      if (in_run && !memwrite && (cycle_count != TIMEOUT_LAST) &&
          (cycle_count != 32'hFFFF_FFFF)) begin
        cycle_count <= cycle_count + 32'h0000_0001;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_req && !push) begin
        log_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_adr[wr_ptr[IDX_W-1:0]]  <= dataadr;
      mem_data[wr_ptr[IDX_W-1:0]] <= writedata;
    end
  end

  assign log_valid = !empty;
  assign log_adr   = empty ? 32'h0 : mem_adr[rd_ptr[IDX_W-1:0]];
  assign log_data  = empty ? 32'h0 : mem_data[rd_ptr[IDX_W-1:0]];

endmodule
`default_nettype wire
